log_divider_pipe: RTL and testbench

//  Pipelined Mitchell log-domain divider, the inverse operation of the log-domain multiplier.

---
 rtl/ldiv_pkg.sv | 27 ++
 rtl/log_lod_conv.sv | 52 +++++
 rtl/log_divider_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_log_divider_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldiv_pkg.sv
// ldiv_pkg
//   Shared constants for the Mitchell log-domain divider.
//   The log value is a signed fixed-point number with LOG_INT_W integer bits
//   and LOG_FRAC_W fraction bits.
//   The antilog mantissa is MANT_ONE + fraction, which is 1.f in Q.LOG_FRAC_W.
//   The saturation limits are symmetric.
//   The most negative code is never produced, so a clipped negative result is
//   the exact negation of a clipped positive one.
package ldiv_pkg;

  localparam int LOG_FRAC_W = 12;
  localparam int LOG_INT_W  = 7;
  localparam int LOG_W      = LOG_INT_W + LOG_FRAC_W;
  localparam int MANT_ONE   = 4096;
  localparam int MANT_W     = LOG_FRAC_W + 1;

  // Largest positive quotient code for a given operand width.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Most negative quotient code the divider emits (symmetric with sat_max).
  function automatic int sat_min(input int width);
    return -sat_max(width);
  endfunction

endpackage

// File: rtl/log_lod_conv.sv
// log_lod_conv
//   Combinational leading-one detector and Mitchell fraction extractor.
//   The input is an unsigned magnitude.
//   The fraction holds the bits below the leading one, left-aligned and
//   truncated to LOG_FRAC_W bits.
//   When the input has fewer bits below the leading one, the fraction is
//   padded with zeros.
// Ports
//   data      in   WIDTH       unsigned magnitude
//   pos       out  POS_W       index of the leading one (0 when data == 0)
//   valid     out  1           data is non-zero
//   fraction  out  LOG_FRAC_W  bits below the leading one, left-aligned
module log_lod_conv
  import ldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]      data,
  output logic [POS_W-1:0]      pos,
  output logic                  valid,
  output logic [LOG_FRAC_W-1:0] fraction
);

  localparam int EXT_W = WIDTH + LOG_FRAC_W;

  logic [EXT_W-1:0] ext;
  logic             ext_unused;

  always_comb begin
    pos   = '0;
    valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        pos   = POS_W'(i);
        valid = 1'b1;
      end
    end
  end

  // Normalise so the leading one sits at the top bit of ext.
  // The LOG_FRAC_W bits right under it are then the fraction.
  // The zero tail appended to data supplies the padding for small magnitudes.
  always_comb begin
    ext      = {data, {LOG_FRAC_W{1'b0}}} << (WIDTH - 1 - int'(pos));
    fraction = ext[EXT_W-2 -: LOG_FRAC_W];
  end

  // The leading one itself and the bits shifted below the fraction are dropped.
  assign ext_unused = ^{ext[EXT_W-1], ext[WIDTH-2:0]};

endmodule

// File: rtl/log_divider_pipe.sv
// log_divider_pipe
//   Three-stage pipelined Mitchell log-domain divider:
//     quot = sign * alog2(log2|num| - log2|den|)
//   S1 : sign, magnitudes, leading-one position and fraction of both operands.
//   S2 : log-domain difference d (signed Q7.12), split into e and f.
//   S3 : antilog shift, saturation, sign restore and special cases.
//        The result is registered as quot, div0 and sat.
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand pair present
//   in_ready   out  1      operand pair accepted this cycle
//   num        in   WIDTH  dividend, signed, QP1 fractional bits
//   den        in   WIDTH  divisor, signed, QP2 fractional bits
//   out_valid  out  1      quotient present
//   out_ready  in   1      downstream takes the quotient this cycle
//   quot       out  WIDTH  quotient, signed, QO fractional bits
//   div0       out  1      divisor was zero
//   sat        out  1      quotient magnitude was clipped
module log_divider_pipe
  import ldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int QP1   = 12,
  parameter int QP2   = 12,
  parameter int QO    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic             div0,
  output logic             sat
);

  localparam int POS_W  = $clog2(WIDTH);
  localparam int WIDE_W = MANT_W + WIDTH;
  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] Q_MIN = WIDTH'(sat_min(WIDTH));

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high.
  // Each stage loads when it is empty or when the stage after it is unloading
  // (en3 <- out_ready, en2 <- en3, en1 <- en2).
  // in_ready is en1.
  // A full pipe therefore accepts and delivers in the same cycle while
  // out_ready is high.
  // A stalled output register holds quot, div0 and sat stable.
  logic en1, en2, en3;
  logic v1, v2;

  assign en3      = !out_valid || out_ready;
  assign en2      = !v2 || en3;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
    end
  end

  // ---------------------------------------------------------------- S1
  logic [WIDTH-1:0]      abs_a, abs_b;
  logic [POS_W-1:0]      pos_a, pos_b;
  logic                  nz_a, nz_b;
  logic [LOG_FRAC_W-1:0] frac_a, frac_b;

  // Two's-complement magnitude taken as unsigned, so -2^(W-1) becomes 2^(W-1).
  assign abs_a = num[WIDTH-1] ? (~num + WIDTH'(1)) : num;
  assign abs_b = den[WIDTH-1] ? (~den + WIDTH'(1)) : den;

  log_lod_conv #(.WIDTH(WIDTH)) u_lod_a (
    .data     (abs_a),
    .pos      (pos_a),
    .valid    (nz_a),
    .fraction (frac_a)
  );

  log_lod_conv #(.WIDTH(WIDTH)) u_lod_b (
    .data     (abs_b),
    .pos      (pos_b),
    .valid    (nz_b),
    .fraction (frac_b)
  );

  logic                  s1_sign, s1_a_neg, s1_za, s1_zb;
  logic [POS_W-1:0]      s1_pos_a, s1_pos_b;
  logic [LOG_FRAC_W-1:0] s1_frac_a, s1_frac_b;

  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_sign   <= num[WIDTH-1] ^ den[WIDTH-1];
      s1_a_neg  <= num[WIDTH-1];
      s1_za     <= !nz_a;
      s1_zb     <= !nz_b;
      s1_pos_a  <= pos_a;
      s1_pos_b  <= pos_b;
      s1_frac_a <= frac_a;
      s1_frac_b <= frac_b;
    end
  end

  // ---------------------------------------------------------------- S2
  // d = (pos_a - pos_b + QP2 - QP1 + QO) * 2^12 + frac_a - frac_b.
  // The format offset makes the integer part of d the binary exponent of the
  // quotient expressed in QO units.
  logic signed [LOG_W-1:0] d;

  assign d = LOG_W'((int'(s1_pos_a) - int'(s1_pos_b) + (QP2 - QP1 + QO)) * MANT_ONE
                    + int'(s1_frac_a) - int'(s1_frac_b));

  logic signed [LOG_INT_W-1:0]  s2_e;
  logic        [LOG_FRAC_W-1:0] s2_f;
  logic                         s2_sign, s2_a_neg, s2_za, s2_zb;

  always_ff @(posedge clk) begin
    if (en2 && v1) begin
      // The top bits of d taken as a signed value give floor(d / 2^12).
      s2_e     <= d[LOG_W-1:LOG_FRAC_W];
      s2_f     <= d[LOG_FRAC_W-1:0];
      s2_sign  <= s1_sign;
      s2_a_neg <= s1_a_neg;
      s2_za    <= s1_za;
      s2_zb    <= s1_zb;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [MANT_W-1:0] mant;
  logic [WIDE_W-1:0] wide;
  logic [WIDTH-1:0]  mag, res_q;
  logic              ovf;
  int                e_int;

  assign mant = MANT_W'(MANT_ONE + int'(s2_f));

  // alog2(e.f) ~= 1.f * 2^e, with 1.f held as Q.12.
  // The shift distance relative to the binary point is therefore e - 12.
  // For e < -1 the mantissa shifts out completely, so wide stays zero.
  // e is capped first, so every shift that is taken fits inside wide.
  always_comb begin
    e_int = int'(s2_e);
    wide  = '0;
    ovf   = 1'b0;
    if (e_int >= WIDTH + LOG_FRAC_W - 1) begin
      ovf = 1'b1;
    end else if (e_int >= LOG_FRAC_W) begin
      wide = WIDE_W'(mant) << (e_int - LOG_FRAC_W);
    end else if (e_int >= -1) begin
      wide = WIDE_W'(mant) >> (LOG_FRAC_W - e_int);
    end
    if (wide > WIDE_W'(Q_MAX)) ovf = 1'b1;
    mag   = ovf ? Q_MAX : wide[WIDTH-1:0];
    res_q = s2_sign ? -mag : mag;
  end

  logic [WIDTH-1:0] q_next;
  logic             div0_next, sat_next;

  // Divide-by-zero wins over a zero dividend.
  // 0/0 reports div0 with a zero quotient.
  always_comb begin
    q_next    = res_q;
    div0_next = 1'b0;
    sat_next  = ovf;
    if (s2_zb) begin
      div0_next = 1'b1;
      sat_next  = 1'b0;
      if (s2_za)         q_next = '0;
      else if (s2_a_neg) q_next = Q_MIN;
      else               q_next = Q_MAX;
    end else if (s2_za) begin
      q_next   = '0;
      sat_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      quot      <= '0;
      div0      <= 1'b0;
      sat       <= 1'b0;
    end else if (en3) begin
      out_valid <= v2;
      if (v2) begin
        quot <= q_next;
        div0 <= div0_next;
        sat  <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_log_divider_pipe.sv
// tb_log_divider_pipe
//   Bench for log_divider_pipe with default parameters (Q4.12 in and out).
//   A monitor on the falling edge does two things.
//   It pushes model results for every accepted operand pair.
//   It pops and compares them for every delivered quotient.
//   Scenario tasks add directed checks on values, latency, backpressure and
//   reset.
module tb_log_divider_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] num = '0;
  logic [W-1:0] den = '0;
  logic         in_ready, out_valid, div0, sat;
  logic [W-1:0] quot;

  int checks = 0;
  int errors = 0;

  logic [W+1:0]   exp_q[$];
  logic [2*W-1:0] pair_q[$];
  logic [W+1:0]   exp_v;
  logic [2*W-1:0] pair_v;
  real            t_real, q_real, err_real;
  logic           sweep_done;

  // ---------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  log_divider_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .div0      (div0),
    .sat       (sat)
  );

  // ---------------------------------------------------------- reference model
  // Returns {div0, sat, quot}.
  function automatic logic [W+1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ua, ub, q;
    int           pa, pb, fa, fb, d, e, f;
    longint       mag;
    logic         sg, s, dz;
    sg = a[W-1] ^ b[W-1];
    ua = a[W-1] ? (~a + 16'd1) : a;
    ub = b[W-1] ? (~b + 16'd1) : b;
    s  = 1'b0;
    dz = 1'b0;
    q  = '0;
    if (b == '0) begin
      dz = 1'b1;
      if (a == '0)      q = 16'h0000;
      else if (a[W-1])  q = 16'h8001;
      else              q = 16'h7FFF;
    end else if (a != '0) begin
      pa = 0;
      pb = 0;
      for (int i = 0; i < W; i++) begin
        if (ua[i]) pa = i;
        if (ub[i]) pb = i;
      end
      // Fraction below the leading one, scaled to 12 bits and truncated.
      fa = ((int'(ua) - (1 << pa)) * 4096) >> pa;
      fb = ((int'(ub) - (1 << pb)) * 4096) >> pb;
      d  = (pa - pb + 12) * 4096 + fa - fb;
      e  = d >>> 12;
      f  = d & 4095;
      if (e < -1)       mag = 0;
      else if (e >= 12) mag = longint'(4096 + f) << (e - 12);
      else              mag = longint'(4096 + f) >> (12 - e);
      if (e >= W + 11 || mag > 32767) begin
        mag = 32767;
        s   = 1'b1;
      end
      q = sg ? W'(-mag) : W'(mag);
    end
    return {dz, s, q};
  endfunction

  function automatic logic [W-1:0] rand_op();
    int v;
    v = $urandom_range(0, 65535) >> $urandom_range(0, 15);
    if ($urandom_range(0, 1) == 1) v = -v;
    if ($urandom_range(0, 31) == 0) v = 0;
    return W'(v);
  endfunction

  // ---------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_div(num, den));
        pair_q.push_back({num, den});
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got quot=%h div0=%b sat=%b, required no output",
                   quot, div0, sat);
        end else begin
          exp_v  = exp_q.pop_front();
          pair_v = pair_q.pop_front();
          if ({div0, sat, quot} !== exp_v) begin
            errors++;
            $display("FAIL out_model: num=%h den=%h got div0=%b sat=%b quot=%h, required div0=%b sat=%b quot=%h",
                     pair_v[2*W-1:W], pair_v[W-1:0], div0, sat, quot,
                     exp_v[W+1], exp_v[W], exp_v[W-1:0]);
          end
          // Mitchell division overestimates by at most 12.5% (at x_a -> 1,
          // x_b = 0.5).
          // The truncations can pull the result down by about one LSB.
          if (!div0 && !sat && pair_v[W-1:0] != '0) begin
            checks++;
            t_real   = real'(int'($signed(pair_v[2*W-1:W]))) * 4096.0
                       / real'(int'($signed(pair_v[W-1:0])));
            q_real   = real'(int'($signed(quot)));
            err_real = q_real - t_real;
            if (err_real < 0.0) err_real = -err_real;
            if (t_real < 0.0) t_real = -t_real;
            if (err_real > 0.126 * t_real + 2.0) begin
              errors++;
              $display("FAIL out_error_bound: num=%h den=%h got quot=%h, required |err| <= 12.6%% of %f",
                       pair_v[2*W-1:W], pair_v[W-1:0], quot, t_real);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int   n;
    logic acc;
    in_valid = 1'b1;
    num      = a;
    den      = b;
    n        = 0;
    acc      = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept: num=%h den=%h not accepted after %0d cycles, required acceptance",
               a, b, n);
    end
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic ed, input logic es,
                         input string name);
    int n;
    out_ready = 1'b1;
    send(a, b);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s: no out_valid within 20 cycles, required a result", name);
    end else if ({div0, sat, quot} !== {ed, es, eq}) begin
      errors++;
      $display("FAIL %s: got quot=%h div0=%b sat=%b, required quot=%h div0=%b sat=%b",
               name, quot, div0, sat, eq, ed, es);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------- scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if ({quot, div0, sat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got quot=%h div0=%b sat=%b, required all 0", quot, div0, sat);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(16'h3000, 16'h1000);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b two edges after accept, required 0", out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, div0, sat, quot} !== {1'b1, 1'b0, 1'b0, 16'h3000}) begin
      errors++;
      $display("FAIL latency_result: got valid=%b quot=%h div0=%b sat=%b, required valid=1 quot=3000 div0=0 sat=0",
               out_valid, quot, div0, sat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_values();
    run_one(16'h1000, 16'h2000, 16'h0800, 1'b0, 1'b0, "val_half");
    run_one(16'hD000, 16'h1000, 16'hD000, 1'b0, 1'b0, "val_neg");
    run_one(16'h7FFF, 16'h0010, 16'h7FFF, 1'b0, 1'b1, "val_sat");
    run_one(16'h8000, 16'hF000, 16'h7FFF, 1'b0, 1'b1, "val_minint_sat");
    run_one(16'h3000, 16'h0000, 16'h7FFF, 1'b1, 1'b0, "val_div0_pos");
    run_one(16'hC000, 16'h0000, 16'h8001, 1'b1, 1'b0, "val_div0_neg");
    run_one(16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, "val_zero_zero");
    run_one(16'h0000, 16'h1000, 16'h0000, 1'b0, 1'b0, "val_zero_num");
    run_one(16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, "val_underflow");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pa [6];
    logic [W-1:0] pb [6];
    logic [W-1:0] first_q;
    pa = '{16'h3000, 16'h1000, 16'hD000, 16'h0400, 16'h7000, 16'hF800};
    pb = '{16'h1000, 16'h2000, 16'h1000, 16'h0300, 16'hE000, 16'h0100};
    first_q   = ref_div(pa[0], pb[0]) >> 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(pa[i], pb[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_full: got in_ready=%b out_valid=%b, required in_ready=0 out_valid=1",
                   in_ready, out_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || quot !== first_q) begin
          errors++;
          $display("FAIL bp_hold: got in_ready=%b quot=%h, required in_ready=0 quot=%h",
                   in_ready, quot, first_q);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_gap: result %0d got out_valid=%b, required 1", i, out_valid);
          end
        end
      end
    join
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_flight();
    out_ready = 1'b0;
    send(16'h3000, 16'h1000);
    send(16'h1000, 16'h2000);
    send(16'hD000, 16'h1000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pair_q.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_flight: got out_valid=%b in_ready=%b, required out_valid=0 in_ready=1",
               out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale: cycle %0d got out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random_sweep();
    int n;
    sweep_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_op(), rand_op());
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------- sequence / report
  initial begin
    test_reset();
    test_latency();
    test_values();
    test_backpressure();
    test_reset_in_flight();
    test_random_sweep();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
